score_timer_display: RTL



---
 rtl/score_display_pkg.sv | 24 ++
 rtl/bin2bcd_seq.sv | 55 +++++
 rtl/score_timer_display.sv | 139 +++++++++++++
 3 files changed

// File: rtl/score_display_pkg.sv
// Seven-segment constants, conversion FSM states and segment decoders
// shared by the score/timer/speed display block.
package score_display_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_DIGIT [0:9] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                              7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
  localparam int SCORE_MAX = 9999;

  typedef enum logic [1:0] {IDLE, CONV_SCORE, CONV_TIMER, LOAD} state_t;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    if (d > 4'd9) return SEG_BLANK;
    return SEG_DIGIT[d];
  endfunction

  // Level 0/1/2 is shown as speed 1/2/3; the unused encoding shows a dash.
  function automatic logic [6:0] speed_seg(input logic [1:0] lvl);
    if (lvl == 2'd3) return SEG_DASH;
    return SEG_DIGIT[{2'b00, lvl} + 4'd1];
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary to BCD converter: one input bit per clock,
// W clocks per conversion after the start cycle loads the operand.
module bin2bcd_seq #(
  parameter int W      = 14,
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_start,
  input  logic [W-1:0]        i_bin,
  output logic [4*DIGITS-1:0] o_bcd,
  output logic                o_busy,
  output logic                o_done
);
  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(W + 1);

  logic [W-1:0]  r_bin;
  logic [BW-1:0] r_bcd;
  logic [BW-1:0] w_adj;
  logic [CW-1:0] r_cnt;
  logic          r_busy;

  always_comb begin
    w_adj = r_bcd;
    for (int d = 0; d < DIGITS; d++) begin
      if (r_bcd[4*d +: 4] > 4'd4) w_adj[4*d +: 4] = r_bcd[4*d +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bin  <= '0;
      r_bcd  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
    end else if (i_start) begin
      r_bin  <= i_bin;
      r_bcd  <= '0;
      r_cnt  <= CW'(W);
      r_busy <= 1'b1;
    end else if (r_busy) begin
      r_bcd <= BW'({w_adj, r_bin[W-1]});
      r_bin <= {r_bin[W-2:0], 1'b0};
      r_cnt <= r_cnt - 1'b1;
      if (r_cnt == CW'(1)) r_busy <= 1'b0;
    end
  end

  // Done flags the final shift so the consumer can act on the same edge.
  assign o_done = r_busy && (r_cnt == CW'(1));
  assign o_busy = r_busy;
  assign o_bcd  = r_bcd;

endmodule

// File: rtl/score_timer_display.sv
// Snapshots score/timer, converts them to BCD and drives active-low
// seven-segment digits; blinks the score while game_over is high.
module score_timer_display
  import score_display_pkg::*;
#(
  parameter int CLK_HZ   = 50_000_000,
  parameter int BLINK_HZ = 2,
  parameter int SCORE_W  = 14,
  parameter int TIMER_W  = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [SCORE_W-1:0] i_score,
  input  logic [TIMER_W-1:0] i_timer,
  input  logic [1:0]         i_speed_level,
  input  logic               i_game_over,
  output logic [27:0]        o_hex_score,
  output logic [13:0]        o_hex_timer,
  output logic [6:0]         o_hex_speed,
  output logic               o_conv_busy
);
  localparam int HALF_RAW = CLK_HZ / (2 * BLINK_HZ);
  localparam int HALF     = (HALF_RAW < 1) ? 1 : HALF_RAW;
  localparam int BCW      = ($clog2(HALF) > 0) ? $clog2(HALF) : 1;

  state_t             r_state;
  logic [SCORE_W-1:0] r_score_snap;
  logic [TIMER_W-1:0] r_timer_snap;
  logic               r_snap_vld;
  logic               r_busy;
  logic [27:0]        r_hex_score;
  logic [13:0]        r_hex_timer;
  logic [1:0]         r_speed;
  logic               r_speed_vld;
  logic [BCW-1:0]     r_blink_cnt;
  logic               r_blink_on;

  logic [SCORE_W-1:0] w_score_clamp;
  logic               w_change;
  logic               w_latch;
  logic               w_timer_start;
  logic [15:0]        w_score_bcd;
  logic [7:0]         w_timer_bcd;
  logic               w_score_busy;
  logic               w_score_done;
  logic               w_timer_busy;
  logic               w_timer_done;

  assign w_score_clamp = (i_score > SCORE_W'(SCORE_MAX)) ? SCORE_W'(SCORE_MAX) : i_score;
  assign w_change      = !r_snap_vld || (i_score != r_score_snap) || (i_timer != r_timer_snap);
  assign w_latch       = (r_state == IDLE) && w_change && !w_score_busy && !w_timer_busy;
  assign w_timer_start = (r_state == CONV_SCORE) && w_score_done;

  bin2bcd_seq #(.W(SCORE_W), .DIGITS(4)) u_score_bcd (
    .clk     (clk),
    .rst     (rst),
    .i_start (w_latch),
    .i_bin   (w_score_clamp),
    .o_bcd   (w_score_bcd),
    .o_busy  (w_score_busy),
    .o_done  (w_score_done)
  );

  bin2bcd_seq #(.W(TIMER_W), .DIGITS(2)) u_timer_bcd (
    .clk     (clk),
    .rst     (rst),
    .i_start (w_timer_start),
    .i_bin   (r_timer_snap),
    .o_bcd   (w_timer_bcd),
    .o_busy  (w_timer_busy),
    .o_done  (w_timer_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_score_snap <= '0;
      r_timer_snap <= '0;
      r_snap_vld   <= 1'b0;
      r_busy       <= 1'b0;
      r_hex_score  <= {4{SEG_BLANK}};
      r_hex_timer  <= {2{SEG_BLANK}};
    end else begin
      case (r_state)
        IDLE: begin
          if (w_latch) begin
            r_score_snap <= i_score;
            r_timer_snap <= i_timer;
            r_snap_vld   <= 1'b1;
            r_busy       <= 1'b1;
            r_state      <= CONV_SCORE;
          end
        end
        CONV_SCORE: if (w_score_done) r_state <= CONV_TIMER;
        CONV_TIMER: if (w_timer_done) r_state <= LOAD;
        LOAD: begin
          r_hex_score <= {seg_decode(w_score_bcd[15:12]), seg_decode(w_score_bcd[11:8]),
                          seg_decode(w_score_bcd[7:4]),   seg_decode(w_score_bcd[3:0])};
          r_hex_timer <= {seg_decode(w_timer_bcd[7:4]), seg_decode(w_timer_bcd[3:0])};
          r_busy      <= 1'b0;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_speed     <= 2'd0;
      r_speed_vld <= 1'b0;
    end else begin
      r_speed     <= i_speed_level;
      r_speed_vld <= 1'b1;
    end
  end

  // Counter idles at zero with the phase "on", so a rising game_over starts lit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_blink_cnt <= '0;
      r_blink_on  <= 1'b1;
    end else if (!i_game_over) begin
      r_blink_cnt <= '0;
      r_blink_on  <= 1'b1;
    end else if (r_blink_cnt == BCW'(HALF - 1)) begin
      r_blink_cnt <= '0;
      r_blink_on  <= !r_blink_on;
    end else begin
      r_blink_cnt <= r_blink_cnt + 1'b1;
    end
  end

  assign o_hex_score = r_blink_on ? r_hex_score : {4{SEG_BLANK}};
  assign o_hex_timer = r_hex_timer;
  assign o_hex_speed = r_speed_vld ? speed_seg(r_speed) : SEG_BLANK;
  assign o_conv_busy = r_busy;

endmodule
